// File: rtl/mem_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mem_stage : load/store pipeline stage (valid/ready request, valid response) |
// | Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.  Rev 1.0      |
// +-----------------------------------------------------------------------------+

package riscv;
  localparam logic [31:0] I_NOP = 32'h0000_0013;
endpackage

package core;
  typedef enum logic [3:0] {
    MEM_NOP = 4'd0, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_op_t;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT
  } alu_op_t;

  typedef enum logic [2:0] {
    NOP = 3'd0, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
  } format_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    format_t     format;
    alu_op_t     alu_op;
    mem_op_t     mem_op;
    logic [4:0]  rd;
    logic [31:0] rd_res;
  } pipeline_bus_t;

  typedef struct packed {
    mem_op_t     mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cntrl_bus_t;
endpackage

module mem_stage #(
  parameter int RSP_TIMEOUT = 256,
  parameter int TMO_W       = $clog2(RSP_TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  core::pipeline_bus_t  bus_i,
  input  core::mem_cntrl_bus_t ex2mem_i,
  output core::pipeline_bus_t  mem_bus_o,
  output logic                 stall_o,
  output logic                 bus_err_o,
  output logic                 dmem_req_valid_o,
  input  logic                 dmem_req_ready_i,
  output logic [31:0]          dmem_addr_o,
  output logic                 dmem_we_o,
  output logic [3:0]           dmem_be_o,
  output logic [31:0]          dmem_wdata_o,
  input  logic                 dmem_rsp_valid_i,
  input  logic [31:0]          dmem_rdata_i,
  output logic                 misalign_o
);

  localparam int CNT_W = (TMO_W < 1) ? 1 : TMO_W;

  localparam core::pipeline_bus_t c_bus_rst = '{
    pc: 32'd0, instr: riscv::I_NOP, format: core::NOP, alu_op: core::ALU_NOP,
    mem_op: core::MEM_NOP, rd: 5'd0, rd_res: 32'd0
  };

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_RSP = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  core::pipeline_bus_t r_bus, w_bus_nxt;
  logic                r_err, w_err_nxt;
  logic [31:0]         r_addr, r_wdata;
  logic [3:0]          r_be;
  logic                r_we;
  core::mem_op_t       r_op;

  logic                w_stall, w_issue, w_is_store, w_tmo_hit, w_misalign;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata, w_shift, w_load;

  assign w_is_store = (ex2mem_i.mem_op == core::MEM_SB) ||
                      (ex2mem_i.mem_op == core::MEM_SH) ||
                      (ex2mem_i.mem_op == core::MEM_SW);

  // Loads present a full-word read; their lane selection happens on the response.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = 32'd0;
    case (ex2mem_i.mem_op)
      core::MEM_SB: begin
        w_be    = 4'b0001 << ex2mem_i.addr[1:0];
        w_wdata = {4{ex2mem_i.wdata[7:0]}};
      end
      core::MEM_SH: begin
        w_be    = ex2mem_i.addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{ex2mem_i.wdata[15:0]}};
      end
      core::MEM_SW: w_wdata = ex2mem_i.wdata;
      default: ;
    endcase
  end

  assign w_shift = dmem_rdata_i >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load = dmem_rdata_i;
    case (r_op)
      core::MEM_LB:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      core::MEM_LH:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
      core::MEM_LBU: w_load = {24'd0, w_shift[7:0]};
      core::MEM_LHU: w_load = {16'd0, w_shift[15:0]};
      default: ;
    endcase
  end

  generate
    if (RSP_TIMEOUT > 0) begin : g_tmo
      assign w_tmo_hit = (r_cnt == CNT_W'(RSP_TIMEOUT));
    end else begin : g_no_tmo
      assign w_tmo_hit = 1'b0;
    end
  endgenerate

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_mis;
  assign w_misalign =
      (((ex2mem_i.mem_op == core::MEM_LH) || (ex2mem_i.mem_op == core::MEM_LHU) ||
        (ex2mem_i.mem_op == core::MEM_SH)) && ex2mem_i.addr[0]) ||
      (((ex2mem_i.mem_op == core::MEM_LW) || (ex2mem_i.mem_op == core::MEM_SW)) &&
        (ex2mem_i.addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bus_nxt   = r_bus;
    w_err_nxt   = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ex2mem_i.mem_op == core::MEM_NOP) begin
          w_bus_nxt = bus_i;
        end else if (w_misalign) begin
          w_bus_nxt        = bus_i;
          w_bus_nxt.rd_res = ex2mem_i.addr;
        end else begin
          w_stall     = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        if (dmem_req_ready_i) begin
          if (r_we) begin
            w_stall     = 1'b0;
            w_bus_nxt   = bus_i;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_WAIT_RSP;
          end
        end
      end
      S_WAIT_RSP: begin
        if (dmem_rsp_valid_i) begin
          w_bus_nxt        = bus_i;
          w_bus_nxt.rd_res = w_load;
          w_state_nxt      = S_IDLE;
        end else if (w_tmo_hit) begin
          w_bus_nxt        = bus_i;
          w_bus_nxt.rd_res = 32'd0;
          w_err_nxt        = 1'b1;
          w_state_nxt      = S_IDLE;
        end else begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_issue = (r_state == S_IDLE) && (w_state_nxt == S_REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bus   <= c_bus_rst;
      r_err   <= 1'b0;
      r_addr  <= 32'd0;
      r_be    <= 4'd0;
      r_wdata <= 32'd0;
      r_we    <= 1'b0;
      r_op    <= core::MEM_NOP;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bus   <= w_bus_nxt;
      r_err   <= w_err_nxt;
      if (w_issue) begin
        r_addr  <= ex2mem_i.addr;
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_we    <= w_is_store;
        r_op    <= ex2mem_i.mem_op;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) r_mis <= 1'b0;
    else     r_mis <= (r_state == S_IDLE) && (ex2mem_i.mem_op != core::MEM_NOP) && w_misalign;
  end
  assign misalign_o = r_mis;
`else
  assign misalign_o = 1'b0;
`endif

  // Reset must release upstream immediately, even mid-access.
  assign stall_o          = w_stall & ~rst;
  assign dmem_req_valid_o = (r_state == S_REQ) & ~rst;
  assign dmem_addr_o      = {r_addr[31:2], 2'b00};
  assign dmem_we_o        = r_we;
  assign dmem_be_o        = r_be;
  assign dmem_wdata_o     = r_wdata;
  assign mem_bus_o        = r_bus;
  assign bus_err_o        = r_err;

endmodule

`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. Consumes the registered execute-stage outputs: pipeline bus and memory control bus `ex2mem`.
- Acts as the responder/consumer end of the `ex2mem` interface. Issues load/store requests to data memory over a valid/ready request channel plus a valid-only response channel.
- Aligns and extends load data, stalls the upstream pipeline while an access is outstanding, and registers the result toward writeback.

Parameters:
- RSP_TIMEOUT, 256, max cycles in WAIT_RSP before abandoning a load. 0 disables the timeout.
- TMO_W, $clog2(RSP_TIMEOUT+1), width of the timeout counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- bus_i  in  core::pipeline_bus_t  instruction/result bus from execute.
- ex2mem_i  in  core::mem_cntrl_bus_t  fields used: mem_op, addr[31:0], wdata[31:0].
- mem_bus_o  out  core::pipeline_bus_t  registered bus to writeback.
- stall_o  out  1  hold execute and earlier stages.
- bus_err_o  out  1  one-cycle pulse on load timeout.
- dmem_req_valid_o  out  1  request valid.
- dmem_req_ready_i  in  1  memory accepts request.
- dmem_addr_o  out  32  word-aligned address: addr[31:2], 2'b00.
- dmem_we_o  out  1  1 = store.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  store data, lane-replicated.
- dmem_rsp_valid_i  in  1  load data valid.
- dmem_rdata_i  in  32  load data word.
- misalign_o  out  1  misaligned access flag; see Optional Feature.

Behaviour:
- Reset values (rst high at posedge):
  - State IDLE; timeout counter 0.
  - mem_bus_o all-zero, with mem_op = MEM_NOP, alu_op = ALU_NOP, format = NOP, instr = riscv::I_NOP.
  - dmem_req_valid_o, dmem_we_o, dmem_be_o, dmem_wdata_o, dmem_addr_o, bus_err_o, misalign_o all 0.
  - stall_o is 0 while rst is high.
- FSM states: IDLE, REQ, WAIT_RSP.
- IDLE:
  - mem_op == MEM_NOP: mem_bus_o <= bus_i next edge (1-cycle latency); stall_o = 0.
  - mem_op != MEM_NOP: stall_o = 1 combinationally. Latch addr, be, wdata, we, op; go to REQ.
- REQ:
  - dmem_req_valid_o = 1; request fields stay stable until handshake (valid & ready).
  - Store on handshake: stall_o = 0 that cycle; mem_bus_o <= bus_i; go to IDLE. Store latency is 1 + handshake wait.
  - Load on handshake: go to WAIT_RSP and clear the counter. stall_o stays 1.
- WAIT_RSP:
  - stall_o = 1 until dmem_rsp_valid_i.
  - On dmem_rsp_valid_i: stall_o = 0 that cycle; mem_bus_o <= bus_i with rd_res = aligned load data; go to IDLE.
- Response is never earlier than the cycle after the handshake. dmem_rsp_valid_i outside WAIT_RSP is ignored.
- Timeout (RSP_TIMEOUT > 0):
  - Counter increments each WAIT_RSP cycle without a response.
  - When it reaches RSP_TIMEOUT: rd_res = 0, bus_err_o pulses 1 cycle, stall_o = 0 that cycle, go to IDLE.
  - A response arriving later is ignored.
- Store lanes, with o = addr[1:0]:
  - SB: be = 4'b0001 << o; wdata = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - SW: be = 4'b1111.
- Loads: shifted = rdata >> (8*o). LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW takes the word as-is.
- Upstream holds bus_i/ex2mem_i stable while stall_o = 1. The stage samples them only in IDLE, plus at the completion cycle for mem_bus_o.
- rst mid-access (REQ or WAIT_RSP): abandon immediately, return to IDLE, drop valid. Any in-flight response is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned means LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0.
  - A misaligned access issues no request and stays in IDLE.
  - mem_bus_o <= bus_i with rd_res = addr, and misalign_o = 1 for one cycle.
  - stall_o = 0.
- Undefined:
  - The low address bits are ignored for alignment checking. An SH at o = 3 uses be 4'b1100; LW uses the whole word.
  - misalign_o is tied 0.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, ready low 2 cycles then high -> valid held 3 cycles with be 4'b1111, addr 0x100; stall_o falls on the handshake cycle; mem_bus_o updates the next edge.
- LB addr 0x103, rdata 0x80FF_1234, response 3 cycles after handshake -> rd_res 0xFFFFFF80. The same access as LBU -> 0x00000080.
- LHU addr 0x102, rdata 0xBEEF_0000 -> rd_res 0x0000BEEF. SH addr 0x102, wdata 0x1234 -> be 4'b1100, dmem_wdata_o 0x12341234.
- Load with no response, RSP_TIMEOUT = 4 -> stall for 4 WAIT_RSP cycles, then bus_err_o pulse and rd_res 0. A late rsp_valid has no effect.
- rst asserted during WAIT_RSP, rsp_valid arrives after reset -> outputs at reset values, state IDLE, response ignored. Back-to-back ALU ops then pass through with 1-cycle latency.
- With MEM_MISALIGN_TRAP_EN defined: LW addr 0x102 -> no dmem_req_valid_o, misalign_o = 1 for 1 cycle, rd_res 0x102.
